branch_resolve: RTL and testbench

- Stage directly downstream of the conditional ALU in EX.
- Consumes the ALU's z_flag together with branch/jump decode and computes taken/not-taken and the branch target.
- On a taken branch, issues a registered PC redirect to fetch with a valid/ready handshake, squashes IF/ID for a fixed number of cycles, and stalls EX until the redirect completes.
- Static not-taken prediction; every taken branch is a redirect. Also keeps saturating branch/taken statistics counters.

---
 rtl/branch_resolve_pkg.sv | 5 +
 rtl/branch_resolve_target_calc.sv | 16 +
 rtl/branch_resolve.sv | 78 +++++++
 tb/tb_branch_resolve.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_pkg.sv
// branch_resolve_pkg: redirect FSM state encodings and the sequential PC step
package branch_resolve_pkg;
  typedef enum logic [1:0] {BR_IDLE, BR_REDIRECT, BR_SQUASH} br_state_t;
  localparam logic [31:0] PC_STEP = 32'd4;
endpackage

// File: rtl/branch_resolve_target_calc.sv
// branch_target_calc: pc/imm/rs_val/jr in -> word-aligned target plus misalign flag out
module branch_target_calc
  import branch_resolve_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic [31:0] rs_val,
  input  logic        jr,
  output logic [31:0] target,
  output logic        misalign
);
  logic [31:0] raw;
  assign raw = jr ? rs_val : pc + PC_STEP + {imm[29:0], 2'b00};
  assign target = {raw[31:2], 2'b00};
  assign misalign = |raw[1:0];
endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: EX branch/jump decode + z_flag in; registered fetch redirect (valid/ready), flush, ex_stall, sticky misalign_err and saturating branch/taken counters out
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int SQUASH_CYCLES = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_is_jump,
  input  logic             ex_jr,
  input  logic             z_flag,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_imm,
  input  logic [31:0]      ex_rs_val,
  input  logic             fetch_ready,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic             ex_stall,
  output logic             misalign_err,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);
  localparam int SW = $clog2(SQUASH_CYCLES + 1);
  br_state_t state, state_n;
  logic [SW-1:0] cnt, cnt_n;
  logic accept, taken, redirect, misalign;
  logic [31:0] target;
  branch_target_calc u_calc (
    .pc(ex_pc),
    .imm(ex_imm),
    .rs_val(ex_rs_val),
    .jr(ex_jr),
    .target(target),
    .misalign(misalign)
  );
  assign ex_stall = state != BR_IDLE;
  assign accept = ex_valid & ~ex_stall & (ex_is_branch | ex_is_jump);
  assign taken = ex_is_jump | (ex_is_branch & z_flag);
  assign redirect = accept & taken;
  // SQUASH spans exactly SQUASH_CYCLES cycles after the handshake cycle
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    if (state == BR_IDLE) state_n = redirect ? BR_REDIRECT : BR_IDLE;
    else if (state == BR_REDIRECT && fetch_ready) begin
      state_n = BR_SQUASH;
      cnt_n = SW'(SQUASH_CYCLES);
    end else if (state == BR_SQUASH) begin
      cnt_n = cnt - SW'(1);
      state_n = cnt == SW'(1) ? BR_IDLE : BR_SQUASH;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BR_IDLE;
      cnt <= '0;
      redirect_valid <= 1'b0;
      redirect_pc <= '0;
      flush <= 1'b0;
      misalign_err <= 1'b0;
      branch_cnt <= '0;
      taken_cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      redirect_valid <= state_n == BR_REDIRECT;
      flush <= state_n != BR_IDLE;
      if (redirect) redirect_pc <= target;
      if (redirect && misalign) misalign_err <= 1'b1;
      if (accept) branch_cnt <= branch_cnt + CNT_W'(branch_cnt != '1);
      if (redirect) taken_cnt <= taken_cnt + CNT_W'(taken_cnt != '1);
    end
  end
endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: randomized + directed scoreboard bench for branch_resolve
module tb_branch_resolve;
  localparam int SQ = 2;
  localparam int CW = 4;
  typedef struct {
    logic [31:0] pc;
    logic        mis;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ex_valid, ex_is_branch, ex_is_jump, ex_jr, z_flag, fetch_ready;
  logic [31:0] ex_pc, ex_imm, ex_rs_val;
  logic redirect_valid, flush, ex_stall, misalign_err;
  logic [31:0] redirect_pc;
  logic [CW-1:0] branch_cnt, taken_cnt;
  int vectors = 0;
  int miscompares = 0;
  exp_t q[$];
  logic [CW-1:0] m_b = '0;
  logic [CW-1:0] m_t = '0;
  logic m_mis = 1'b0;
  bit busy = 0;
  int sq_left = 0;
  int rv_cycles = 0;
  int last_wait = 0;
  int hold = 0;
  int ready_pct = 100;
  branch_resolve #(.SQUASH_CYCLES(SQ), .CNT_W(CW)) dut (
    .clk(clk),
    .rst(rst),
    .ex_valid(ex_valid),
    .ex_is_branch(ex_is_branch),
    .ex_is_jump(ex_is_jump),
    .ex_jr(ex_jr),
    .z_flag(z_flag),
    .ex_pc(ex_pc),
    .ex_imm(ex_imm),
    .ex_rs_val(ex_rs_val),
    .fetch_ready(fetch_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .flush(flush),
    .ex_stall(ex_stall),
    .misalign_err(misalign_err),
    .branch_cnt(branch_cnt),
    .taken_cnt(taken_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // fetch side: optionally refuses the first `hold` redirect cycles, then accepts with ready_pct probability
  initial begin
    fetch_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      fetch_ready = hold == 0 && $urandom_range(99) < ready_pct;
      if (redirect_valid && hold > 0) hold--;
    end
  end
  // monitor: pops the scoreboard on each handshake and polices flush/stall shape
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        busy = 0;
        sq_left = 0;
        rv_cycles = 0;
      end else if (redirect_valid) begin
        rv_cycles++;
        if (q.size() == 0) chk("unexpected redirect_valid", redirect_valid, 0);
        else begin
          chk("redirect_pc", redirect_pc, q[0].pc);
          chk("flush during redirect", flush, 1);
          chk("ex_stall during redirect", ex_stall, 1);
          if (fetch_ready) begin
            chk("misalign_err", misalign_err, q[0].mis);
            void'(q.pop_front());
            sq_left = SQ;
            last_wait = rv_cycles;
            rv_cycles = 0;
          end
        end
      end else if (sq_left > 0) begin
        chk("flush during squash", flush, 1);
        chk("ex_stall during squash", ex_stall, 1);
        sq_left--;
        if (sq_left == 0) busy = 0;
      end else begin
        chk("idle flush", flush, 0);
        chk("idle ex_stall", ex_stall, 0);
      end
    end
  end
  task automatic issue(input logic v, input logic br, input logic j, input logic jr, input logic z,
                       input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs);
    logic acc, tk;
    logic [31:0] t;
    @(posedge clk);
    #1;
    ex_valid = v;
    ex_is_branch = br;
    ex_is_jump = j;
    ex_jr = jr;
    z_flag = z;
    ex_pc = pc;
    ex_imm = imm;
    ex_rs_val = rs;
    acc = v & (br | j);
    tk = acc & (j | (br & z));
    t = jr ? rs : pc + 32'd4 + imm * 32'd4;
    if (acc) m_b = (m_b == '1) ? m_b : m_b + 1'b1;
    if (tk) begin
      m_t = (m_t == '1) ? m_t : m_t + 1'b1;
      if (t % 4 != 0) m_mis = 1'b1;
      q.push_back('{pc: t & ~32'd3, mis: m_mis});
      busy = 1;
    end
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    chk("branch_cnt", branch_cnt, m_b);
    chk("taken_cnt", taken_cnt, m_t);
    chk("redirect_valid latency", redirect_valid, tk);
    chk("ex_stall after accept", ex_stall, tk);
  endtask
  // while stalled, keep presenting junk branches that must be ignored
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(posedge clk);
      #1;
      ex_valid = 1'b1;
      ex_is_branch = 1'($urandom);
      ex_is_jump = 1'($urandom);
      ex_jr = 1'($urandom);
      z_flag = 1'($urandom);
      ex_pc = $urandom;
      ex_imm = $urandom;
      ex_rs_val = $urandom;
      n++;
    end
    ex_valid = 1'b0;
    chk("redirect completes", 32'(busy), 0);
    if (busy) begin
      q.delete();
      busy = 0;
    end
  endtask
  initial begin
    {ex_valid, ex_is_branch, ex_is_jump, ex_jr, z_flag} = '0;
    ex_pc = '0;
    ex_imm = '0;
    ex_rs_val = '0;
    #12;
    chk("reset redirect_valid", redirect_valid, 0);
    chk("reset flush", flush, 0);
    chk("reset ex_stall", ex_stall, 0);
    chk("reset misalign_err", misalign_err, 0);
    chk("reset redirect_pc", redirect_pc, 0);
    chk("reset branch_cnt", branch_cnt, 0);
    chk("reset taken_cnt", taken_cnt, 0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    issue(1, 1, 0, 0, 0, 32'h100, 32'd3, 0);
    issue(1, 1, 0, 0, 1, 32'h100, 32'd3, 0);
    wait_idle();
    chk("redirect cycles no backpressure", last_wait, 1);
    hold = 4;
    issue(1, 0, 1, 0, 0, 32'h200, 32'hFFFF_FFFC, 0);
    wait_idle();
    chk("redirect cycles backpressure", last_wait, 5);
    issue(1, 0, 1, 1, 0, 32'h0, 32'h0, 32'h0000_0403);
    wait_idle();
    issue(1, 0, 1, 0, 0, 32'hFFFF_FFFC, 32'h0, 0);
    wait_idle();
    chk("misalign_err sticky", misalign_err, 1);
    ready_pct = 60;
    repeat (80) begin
      issue($urandom_range(7) != 0, 1'($urandom), 1'($urandom), $urandom_range(3) == 0, 1'($urandom),
            $urandom, $urandom_range(1) ? $urandom : 32'($signed($urandom_range(64)) - 32),
            $urandom_range(1) ? $urandom : $urandom & ~32'd3);
      if (busy) wait_idle();
    end
    ready_pct = 100;
    issue(1, 1, 0, 0, 1, 32'h300, 32'd5, 0);
    for (int i = 0; i < 20 && sq_left == 0; i++) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("async reset flush", flush, 0);
    chk("async reset ex_stall", ex_stall, 0);
    chk("async reset redirect_valid", redirect_valid, 0);
    chk("async reset branch_cnt", branch_cnt, 0);
    chk("async reset taken_cnt", taken_cnt, 0);
    chk("async reset misalign_err", misalign_err, 0);
    m_b = '0;
    m_t = '0;
    m_mis = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    issue(1, 1, 0, 0, 1, 32'h100, 32'd3, 0);
    wait_idle();
    repeat (20) begin
      issue(1, 0, 1, 0, 0, $urandom & ~32'd3, $urandom_range(255), 0);
      wait_idle();
    end
    chk("saturated branch_cnt", branch_cnt, 32'hF);
    chk("saturated taken_cnt", taken_cnt, 32'hF);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
